// File: rtl/qar_timer_pkg.sv
// Shared definitions for the QAR-Core machine timer: register offsets, CTRL bits, bus FSM states.
// No logic here; imported by the timer top and the bus wait-state FSM.
package qar_timer_pkg;

   localparam logic [7:0] TMR_CTRL     = 8'h00;
   localparam logic [7:0] TMR_COUNT    = 8'h04;
   localparam logic [7:0] TMR_COMPARE  = 8'h08;
   localparam logic [7:0] TMR_STATUS   = 8'h0C;
   localparam logic [7:0] TMR_PRESCALE = 8'h10;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;

   typedef enum logic [1:0] {
      BUS_IDLE = 2'd0,
      BUS_WAIT = 2'd1,
      BUS_RESP = 2'd2
   } bus_state_e;

endpackage

// File: rtl/qar_bus_wait_fsm.sv
// Generic MMIO target FSM: latches a request, burns WAIT_STATES cycles, then strobes ready for one cycle.
// ready_o follows acceptance by 1+WAIT_STATES cycles; the core holds the request, so no other backpressure.
module qar_bus_wait_fsm
   import qar_timer_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned AW          = 6,
   parameter int unsigned DW          = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          sel_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic          fire_o,
   output logic          we_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] wdata_o,
   output logic          ready_o
);

   bus_state_e    state_q;
   logic [3:0]    ws_cnt_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          ready_q;

   // With zero wait states the access commits straight from IDLE, before the latch is valid.
   assign fire_o  = ((state_q == BUS_IDLE) && sel_i && (WAIT_STATES == 0)) ||
                    ((state_q == BUS_WAIT) && (ws_cnt_q == 4'd0));
   assign we_o    = (state_q == BUS_IDLE) ? we_i    : we_q;
   assign addr_o  = (state_q == BUS_IDLE) ? addr_i  : addr_q;
   assign wdata_o = (state_q == BUS_IDLE) ? wdata_i : wdata_q;
   assign ready_o = ready_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= BUS_IDLE;
         ws_cnt_q <= 4'd0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            BUS_IDLE: begin
               if (sel_i) begin
                  we_q    <= we_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  if (WAIT_STATES == 0) begin
                     state_q <= BUS_RESP;
                     ready_q <= 1'b1;
                  end else begin
                     state_q  <= BUS_WAIT;
                     ws_cnt_q <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            BUS_WAIT: begin
               if (ws_cnt_q == 4'd0) begin
                  state_q <= BUS_RESP;
                  ready_q <= 1'b1;
               end else begin
                  ws_cnt_q <= ws_cnt_q - 4'd1;
               end
            end
            BUS_RESP: state_q <= BUS_IDLE;
            default:  state_q <= BUS_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/qar_timer_responder.sv
// Memory-mapped machine timer on the QAR-Core data bus; responds in 1+WAIT_STATES cycles, one access per WAIT_STATES+2.
// Prescaled COUNT vs COMPARE raises irq_timer; cleared by an acknowledge rising edge or a STATUS write-1.
module qar_timer_responder
   import qar_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        irq_timer,
   input  logic        irq_timer_ack
);

   logic        sel, fire, acc_we;
   logic [5:0]  acc_addr;
   logic [7:0]  acc_off;
   logic [31:0] acc_wdata, rd_val;
   logic        unused_addr_bits;

   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] count_q, count_d, compare_q, compare_d;
   logic [15:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
   logic        pending_q, pending_d;
   logic [1:0]  ack_q;
   logic        irq_q;
   logic [31:0] rdata_q;

   logic wr, wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
   logic tick, match, ack_rise, en_rise;

   assign sel              = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
   assign unused_addr_bits = ^mem_addr[1:0];

   qar_bus_wait_fsm #(.WAIT_STATES(WAIT_STATES), .AW(6), .DW(32)) u_bus (
      .clk_i   (clk),
      .rst_i   (rst),
      .sel_i   (sel),
      .we_i    (mem_we),
      .addr_i  (mem_addr[7:2]),
      .wdata_i (mem_wdata),
      .fire_o  (fire),
      .we_o    (acc_we),
      .addr_o  (acc_addr),
      .wdata_o (acc_wdata),
      .ready_o (mem_ready)
   );

   assign acc_off     = {acc_addr, 2'b00};
   assign wr          = fire && acc_we;
   assign wr_ctrl     = wr && (acc_off == TMR_CTRL);
   assign wr_count    = wr && (acc_off == TMR_COUNT);
   assign wr_compare  = wr && (acc_off == TMR_COMPARE);
   assign wr_status   = wr && (acc_off == TMR_STATUS);
   assign wr_prescale = wr && (acc_off == TMR_PRESCALE);

   assign tick     = ctrl_q[CTRL_EN] && (pre_cnt_q == prescale_q);
   assign match    = tick && (count_q == compare_q);
   assign ack_rise = ack_q[0] && !ack_q[1];
   assign en_rise  = wr_ctrl && acc_wdata[CTRL_EN] && !ctrl_q[CTRL_EN];

   always_comb begin
      rd_val = '0;
      case (acc_off)
         TMR_CTRL:     rd_val = {29'd0, ctrl_q};
         TMR_COUNT:    rd_val = count_q;
         TMR_COMPARE:  rd_val = compare_q;
         TMR_STATUS:   rd_val = {31'd0, pending_q};
         TMR_PRESCALE: rd_val = {16'd0, prescale_q};
         default:      rd_val = '0;
      endcase
   end

   always_comb begin
      ctrl_d     = wr_ctrl     ? acc_wdata[2:0]  : ctrl_q;
      compare_d  = wr_compare  ? acc_wdata       : compare_q;
      prescale_d = wr_prescale ? acc_wdata[15:0] : prescale_q;

      pre_cnt_d = pre_cnt_q;
      if (en_rise)
         pre_cnt_d = '0;
      else if (ctrl_q[CTRL_EN])
         pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;

      // A bus store to COUNT overrides any increment or reload in the same cycle.
      count_d = count_q;
      if (wr_count)
         count_d = acc_wdata;
      else if (tick)
         count_d = (match && ctrl_q[CTRL_AUTO_RELOAD]) ? 32'd0 : count_q + 32'd1;

      pending_d = match || (pending_q && !(ack_rise || (wr_status && acc_wdata[0])));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q     <= '0;
         count_q    <= '0;
         compare_q  <= 32'hFFFF_FFFF;
         prescale_q <= '0;
         pre_cnt_q  <= '0;
         pending_q  <= 1'b0;
         ack_q      <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
         pending_q  <= pending_d;
         ack_q      <= {ack_q[0], irq_timer_ack};
         irq_q      <= pending_q && ctrl_q[CTRL_IRQ_EN];
         rdata_q    <= (fire && !acc_we) ? rd_val : 32'd0;
      end
   end

   assign mem_rdata = rdata_q;
   assign irq_timer = irq_q;

endmodule

// File: doc/qar_timer_responder.md
# qar_timer_responder

Memory-mapped machine timer that acts as a target on the QAR-Core data bus (`mem_valid`/`mem_we`/`mem_addr`/`mem_wdata` → `mem_ready`/`mem_rdata`) and as the source of the core's `irq_timer` request/acknowledge handshake. It answers core loads and stores inside a 256-byte window with a fixed, parameterised number of wait states. It counts prescaled clock ticks, raises `irq_timer` on compare match, and drops it on `irq_timer_ack` or a software clear. It sits beside the data RAM in the SoC top, with its `mem_ready`/`mem_rdata` OR-muxed with the other bus targets.

## Interface
- `BASE_ADDR`, 32'h4000_0000: window base; bits [7:0] must be zero.
- `WAIT_STATES`, 1: extra cycles between request acceptance and `mem_ready`; range 0–15.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_valid` in 1: core request; held with addr/we/wdata stable until `mem_ready`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: byte address; bits [1:0] ignored (word access only).
- `mem_wdata` in 32: store data.
- `mem_ready` out 1: one-cycle response strobe, registered.
- `mem_rdata` out 32: load data, valid with `mem_ready`; 0 at all other times.
- `irq_timer` out 1: level interrupt request.
- `irq_timer_ack` in 1: core acknowledge; rising edge clears pending.

## Operation
- Selection: `sel = mem_valid && mem_addr[31:8] == BASE_ADDR[31:8]`. If `sel` is low, the block never drives `mem_ready`.
- Register map (word offsets in bytes):
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN.
  - 0x04 COUNT: 32-bit, R/W.
  - 0x08 COMPARE: R/W.
  - 0x0C STATUS: [0] PENDING; reads return it, write-1 clears it.
  - 0x10 PRESCALE: [15:0] R/W; upper bits read 0.
- Unmapped offsets: loads return 0, stores are dropped, and the access still completes.
- Bus FSM:
  - IDLE: on `sel`, latch addr/we/wdata. Go to WAIT with `ws_cnt = WAIT_STATES-1`, or go to RESP if `WAIT_STATES == 0`.
  - WAIT: decrement `ws_cnt`; go to RESP when it reaches 0.
  - RESP: assert `mem_ready` for 1 cycle, drive `mem_rdata` (load) or commit the store at this edge; return to IDLE.
- After RESP the FSM always spends 1 cycle in IDLE. A request still asserted then is treated as a new access.
- Prescaler: while EN=1, `pre_cnt` counts 0..PRESCALE. A tick fires when `pre_cnt == PRESCALE`, and `pre_cnt` returns to 0 on that tick. PRESCALE=0 gives a tick every cycle.
- On a tick:
  - If COUNT == COMPARE: set PENDING; COUNT becomes 0 if AUTO_RELOAD is set, otherwise COUNT+1.
  - Otherwise COUNT becomes COUNT+1, 32-bit wrap (0xFFFF_FFFF → 0).
- EN=0 freezes both `pre_cnt` and COUNT. Writing CTRL with EN 0→1 clears `pre_cnt`.
- `irq_timer` = PENDING & IRQ_EN, registered.
- PENDING clears on a rising edge of `irq_timer_ack` (edge detected against a registered copy), or on a STATUS write with bit0=1.
- Simultaneous events:
  - Bus write to COUNT and a tick in the same cycle: the bus value wins and no increment happens.
  - Set and clear of PENDING in the same cycle: set wins.
  - Write to COMPARE in the tick cycle: the match uses the old COMPARE.

## Timing
- Reset values: `mem_ready` 0, `mem_rdata` 0, `irq_timer` 0. CTRL 0, COUNT 0, COMPARE 32'hFFFF_FFFF, PRESCALE 0, PENDING 0, `pre_cnt` 0, FSM IDLE.
- Latency: request seen in IDLE at cycle T → `mem_ready` at T+1+WAIT_STATES. Read data reflects register contents at the edge that enters RESP.
- Throughput: 1 access per WAIT_STATES+2 cycles.
- `irq_timer` rises 1 cycle after PENDING sets and falls 1 cycle after it clears.
- `irq_timer_ack` → PENDING clear: 2 cycles.
- Reset asserted mid-access aborts it: no `mem_ready`, no write. The core must reissue.

## Structure
- Package `qar_timer_pkg` holds:
  - register offsets (`TMR_CTRL`, `TMR_COUNT`, `TMR_COMPARE`, `TMR_STATUS`, `TMR_PRESCALE`);
  - CTRL bit indices;
  - the bus FSM state encoding (IDLE/WAIT/RESP).
- Sub-module `qar_bus_wait_fsm`: the generic wait-state target FSM (latch, count, one-cycle ready). It is reused by later MMIO peripherals. The timer core and register file stay in the top module.

## Test plan
- Reset, then read all 5 registers with WAIT_STATES=1 → 0, 0, 0xFFFF_FFFF, 0, 0, each `mem_ready` exactly 2 cycles after request.
- PRESCALE=3, COMPARE=5, CTRL=0b101 → `irq_timer` high 25±1 cycles after the EN write. COUNT keeps incrementing past 5.
- With `irq_timer` high, pulse `irq_timer_ack` → `irq_timer` low within 3 cycles. COUNT keeps running.
- AUTO_RELOAD=1, COMPARE=2, PRESCALE=0 → PENDING sets every 3 cycles, COUNT sequence 0,1,2,0,…. A STATUS write of 1 in the set cycle leaves PENDING=1.
- Write COUNT=0xFFFF_FFFF, COMPARE=0, EN=1, PRESCALE=0 → COUNT reads 0, PENDING sets on the next tick; the bus write of COUNT in a tick cycle takes precedence.
- Access at BASE+0x40 returns 0 with ready. Access outside the window gets no ready for 20 cycles. Reset during WAIT gives no ready and leaves registers at reset values.
